uart_tx_device: RTL and testbench
=================================

Name: uart_tx_device

Overview:
- Memory-mapped UART transmitter that sits on the system bus as a device slave, next to the RAM, simulator-control and timer slaves.
- Software writes bytes into a TX FIFO; a baud-rate serializer drives an 8N1 serial line.
- Raises a level interrupt toward the core's fast/external IRQ inputs when transmission drains.
- Gives the simple system a real serial console in addition to the simulator log.

Parameters:
- DataWidth, 32, bus data width (only 32 supported)
- AddressWidth, 32, bus address width
- FifoDepth, 8, TX FIFO entries (power of two, >=2)
- DefaultDiv, 16, reset value of the baud divisor (clock cycles per bit)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- dev_req_i  in  1  bus request; always granted by the bus
- dev_we_i  in  1  write enable
- dev_be_i  in  4  byte enables
- dev_addr_i  in  AddressWidth  byte address; only bits [3:2] decoded, [9:4] must be 0
- dev_wdata_i  in  DataWidth  write data
- dev_rvalid_o  out  1  response valid
- dev_rdata_o  out  DataWidth  read data
- dev_err_o  out  1  error response, qualified by dev_rvalid_o
- tx_o  out  1  serial output, idle high
- irq_o  out  1  level interrupt

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Values at reset: dev_rvalid_o=0, dev_rdata_o=0, dev_err_o=0, tx_o=1, irq_o=0, FIFO empty, DIV=DefaultDiv, IRQ_EN=0, OVF=0.
- Bus response: every request cycle gets dev_rvalid_o=1 exactly one cycle later. There is no back-pressure, and back-to-back requests are allowed.
  - dev_rdata_o is registered. It is 0 for writes and for error responses.
- Register map (offset):
  - 0x0 TXDATA: write only. A write with be[0]=1 pushes wdata[7:0]; be[0]=0 is ignored. Reads return 0.
  - 0x4 STATUS: read only. bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 OVF (sticky), bits[7+:8] FIFO level. A write of 1 to bit3 clears OVF.
  - 0x8 DIV: r/w, bits[15:0] hold the divisor. Upper bits read 0. A value of 0 is treated as 1.
  - 0xC IRQ_EN: r/w, bit0.
  - Any other offset, or addr[9:4]!=0: dev_err_o=1 with rvalid, no side effects.
- Push to TXDATA while the FIFO is full: data is dropped and OVF is set. dev_err_o=0.
- Push and pop in the same cycle while full: the pop happens first, the push succeeds, and the level is unchanged.
- FIFO pointers are log2(FifoDepth)+1 bits and wrap naturally. Full means MSBs differ with equal LSBs.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE -> START when the FIFO is non-empty. The byte is popped into a shift register on that transition, and tx_o=0.
  - Each state holds for DIV cycles, counted by a 16-bit counter that reloads on every bit boundary.
  - DATA sends 8 bits LSB first, tracked by a 3-bit index.
  - STOP drives tx_o=1 for DIV cycles, then goes to START if the FIFO is non-empty, else IDLE. There is no idle gap between frames.
  - One frame is exactly 10*DIV cycles.
- DIV is sampled at each bit-counter reload. A write mid-frame takes effect from the next bit.
- irq_o = IRQ_EN & FIFO empty & FSM IDLE, registered (one cycle after the condition).
- Reset asserted mid-frame: tx_o returns to 1 immediately (asynchronous) and the FIFO contents are discarded.

Decomposition:
- Package uart_tx_pkg holds:
  - register offset constants (TXDATA, STATUS, DIV, IRQ_EN)
  - STATUS bit indices
  - the FSM state enum uart_tx_state_e
- Sub-module uart_tx_fifo: synchronous FIFO, parameterized by width and depth, with push/pop/full/empty/level.

Test Plan:
- After reset, read STATUS -> rdata=0x0000_0002 one cycle after req; tx_o=1; irq_o=0.
- DIV=4, write 0xA5 to TXDATA -> tx_o sequence over 40 cycles: 0 (start), then 1,0,1,0,0,1,0,1 (LSB first), then 1 (stop), each held 4 cycles; STATUS.busy=1 during the frame.
- DIV=2, push 9 bytes back-to-back with FifoDepth=8 -> first byte popped after 1 cycle, so all 9 accepted and OVF=0; push 10 more immediately -> OVF=1 and level reads 8; write STATUS bit3=1 -> OVF=0.
- IRQ_EN=1, push 2 bytes with DIV=1 -> frames run contiguously with no idle between stop and start; irq_o rises exactly 1 cycle after the second stop bit ends.
- Read 0x10 and write 0x40 -> rvalid=1 with err=1, rdata=0; no state change. Write DIV=0 -> each bit lasts 1 cycle.
- Assert rst_ni mid DATA bit 3 -> tx_o=1 asynchronously; after release, STATUS=0x2 and DIV=DefaultDiv.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the serializer state encoding.
package uart_tx_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_IRQ_EN = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_LEVEL = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop in the same cycle frees the
// slot for a push even when full.
module uart_tx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 8,
  localparam int AW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_device.sv
// Bus-slave UART transmitter: TX FIFO feeding an 8N1 serializer with a
// programmable per-bit divisor and a drain interrupt.
module uart_tx_device
  import uart_tx_pkg::*;
#(
  parameter int          DataWidth    = 32,
  parameter int          AddressWidth = 32,
  parameter int          FifoDepth    = 8,
  parameter logic [15:0] DefaultDiv   = 16'd16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [3:0]              dev_be_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    tx_o,
  output logic                    irq_o
);

  localparam int LvlW = $clog2(FifoDepth) + 1;

  logic [1:0]           off;
  logic                 addr_ok;
  logic                 wr_en;
  logic                 push;
  logic                 pop;
  logic                 ovf_clr;
  logic                 ovf_q;
  logic [15:0]          div_q;
  logic                 irq_en_q;
  logic [7:0]           fifo_rdata;
  logic                 full;
  logic                 empty;
  logic [LvlW-1:0]      level;
  logic [DataWidth-1:0] rdata_d;
  logic [DataWidth-1:0] status;

  uart_tx_state_e state;
  logic [15:0]    cnt;
  logic [15:0]    reload;
  logic [2:0]     idx;
  logic [7:0]     shreg;

  logic unused_bits;
  assign unused_bits = ^{dev_addr_i[AddressWidth-1:10], dev_addr_i[1:0],
                         dev_wdata_i[DataWidth-1:16], dev_be_i[3:2]};

  assign off     = dev_addr_i[3:2];
  assign addr_ok = (dev_addr_i[9:4] == 6'd0);
  assign wr_en   = dev_req_i & dev_we_i & addr_ok;
  assign push    = wr_en & (off == OFF_TXDATA) & dev_be_i[0];
  assign ovf_clr = wr_en & (off == OFF_STATUS) & dev_be_i[0] & dev_wdata_i[STAT_OVF];

  uart_tx_fifo #(
    .Width (8),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (dev_wdata_i[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q    <= 1'b0;
      div_q    <= DefaultDiv;
      irq_en_q <= 1'b0;
    end else begin
      if (push && full && !pop) ovf_q <= 1'b1;
      else if (ovf_clr)         ovf_q <= 1'b0;
      if (wr_en && off == OFF_DIV) begin
        if (dev_be_i[0]) div_q[7:0]  <= dev_wdata_i[7:0];
        if (dev_be_i[1]) div_q[15:8] <= dev_wdata_i[15:8];
      end
      if (wr_en && off == OFF_IRQ_EN && dev_be_i[0]) irq_en_q <= dev_wdata_i[0];
    end
  end

  always_comb begin
    status             = DataWidth'(level) << STAT_LEVEL;
    status[STAT_FULL]  = full;
    status[STAT_EMPTY] = empty;
    status[STAT_BUSY]  = (state != ST_IDLE);
    status[STAT_OVF]   = ovf_q;
  end

  always_comb begin
    rdata_d = '0;
    if (dev_req_i && !dev_we_i && addr_ok) begin
      case (off)
        OFF_STATUS: rdata_d = status;
        OFF_DIV:    rdata_d = DataWidth'(div_q);
        OFF_IRQ_EN: rdata_d = DataWidth'(irq_en_q);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dev_rvalid_o <= 1'b0;
      dev_err_o    <= 1'b0;
      dev_rdata_o  <= '0;
    end else begin
      dev_rvalid_o <= dev_req_i;
      dev_err_o    <= dev_req_i & ~addr_ok;
      dev_rdata_o  <= rdata_d;
    end
  end

  // A divisor of 0 behaves as 1; the reload value is sampled at every bit boundary.
  assign reload = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
  assign pop    = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & (cnt == 16'd0)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      tx_o  <= 1'b1;
      irq_o <= 1'b0;
    end else begin
      irq_o <= irq_en_q & empty & (state == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state <= ST_START;
            cnt   <= reload;
            tx_o  <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt == 16'd0) begin
            state <= ST_DATA;
            cnt   <= reload;
            idx   <= 3'd0;
            tx_o  <= shreg[0];
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt == 16'd0) begin
            cnt <= reload;
            if (idx == 3'd7) begin
              state <= ST_STOP;
              tx_o  <= 1'b1;
            end else begin
              idx  <= idx + 3'd1;
              tx_o <= shreg[idx + 3'd1];
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          if (cnt == 16'd0) begin
            cnt <= reload;
            if (!empty) begin
              state <= ST_START;
              tx_o  <= 1'b0;
            end else begin
              state <= ST_IDLE;
              tx_o  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (pop) shreg <= fifo_rdata;
  end

endmodule

// File: tb/tb_uart_tx_device.sv
// Directed bench for uart_tx_device: register access, frame timing, FIFO
// overflow, interrupt timing, error responses and mid-frame reset.
module tb_uart_tx_device;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dev_req = 1'b0;
  logic        dev_we = 1'b0;
  logic [3:0]  dev_be = 4'h0;
  logic [31:0] dev_addr = 32'h0;
  logic [31:0] dev_wdata = 32'h0;
  logic        dev_rvalid;
  logic [31:0] dev_rdata;
  logic        dev_err;
  logic        tx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_tx_device #(
    .DataWidth    (32),
    .AddressWidth (32),
    .FifoDepth    (8),
    .DefaultDiv   (16'd16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .dev_req_i    (dev_req),
    .dev_we_i     (dev_we),
    .dev_be_i     (dev_be),
    .dev_addr_i   (dev_addr),
    .dev_wdata_i  (dev_wdata),
    .dev_rvalid_o (dev_rvalid),
    .dev_rdata_o  (dev_rdata),
    .dev_err_o    (dev_err),
    .tx_o         (tx),
    .irq_o        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic rv, output logic er);
    dev_req   = 1'b1;
    dev_we    = we;
    dev_be    = 4'hF;
    dev_addr  = addr;
    dev_wdata = wdata;
    tick();
    dev_req   = 1'b0;
    dev_we    = 1'b0;
    rd = dev_rdata;
    rv = dev_rvalid;
    er = dev_err;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic rv, er;
    bus(1'b1, addr, wdata, rd, rv, er);
    check({tag, "_resp"}, {30'd0, rv, er}, 32'h2);
    check({tag, "_rdata"}, rd, 32'h0);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic rv, er;
    bus(1'b0, addr, 32'h0, rd, rv, er);
    check({tag, "_resp"}, {30'd0, rv, er}, 32'h2);
    check(tag, rd, exp);
  endtask

  initial begin
    logic [9:0]  fr;
    logic [19:0] fr2;
    logic [31:0] rd;
    logic        rv, er, done;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rvalid", {31'd0, dev_rvalid}, 32'd0);
    check("rst_rdata", dev_rdata, 32'd0);
    rdchk("rst_status", 32'h4, 32'h0000_0002);
    rdchk("rst_div", 32'h8, 32'd16);
    rdchk("rst_irq_en", 32'hC, 32'd0);

    // DIV=4, one 0xA5 frame: start, LSB-first data, stop
    wr("div4", 32'h8, 32'd4);
    wr("push_a5", 32'h0, 32'hA5);
    check("pre_start_tx", {31'd0, tx}, 32'd1);
    tick();
    fr = 10'b1_1010_0101_0;
    for (int k = 0; k < 40; k++) begin
      check($sformatf("a5_tx_%0d", k), {31'd0, tx}, {31'd0, fr[k/4]});
      if (k == 20) begin
        dev_req = 1'b1; dev_we = 1'b0; dev_be = 4'hF; dev_addr = 32'h4;
      end
      tick();
      if (k == 20) begin
        dev_req = 1'b0;
        check("busy_rvalid", {31'd0, dev_rvalid}, 32'd1);
        check("busy_status", dev_rdata, 32'h6);
      end
    end
    check("a5_idle_tx", {31'd0, tx}, 32'd1);
    rdchk("a5_done_status", 32'h4, 32'h2);

    // DIV=2: 9 back-to-back pushes fit, 10 more overflow
    wr("div2", 32'h8, 32'd2);
    for (int i = 0; i < 9; i++) wr($sformatf("push9_%0d", i), 32'h0, 32'h10 + i);
    rdchk("status_full", 32'h4, 32'h405);
    for (int i = 0; i < 10; i++) wr($sformatf("pushovf_%0d", i), 32'h0, 32'h80 + i);
    rdchk("status_ovf", 32'h4, 32'h40D);
    wr("clr_ovf", 32'h4, 32'h8);
    rdchk("status_ovf_clr", 32'h4, 32'h384);
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      bus(1'b0, 32'h4, 32'h0, rd, rv, er);
      if (rd == 32'h2) done = 1'b1;
    end
    check("drain_done", {31'd0, done}, 32'd1);

    // IRQ timing with two contiguous DIV=1 frames
    wr("div1", 32'h8, 32'd1);
    wr("irq_en", 32'hC, 32'd1);
    check("irq_low_1cyc", {31'd0, irq}, 32'd0);
    tick();
    check("irq_high_idle", {31'd0, irq}, 32'd1);
    wr("push_55", 32'h0, 32'h55);
    wr("push_0f", 32'h0, 32'h0F);
    fr2 = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 20; k++) begin
      check($sformatf("b2b_tx_%0d", k), {31'd0, tx}, {31'd0, fr2[k]});
      check($sformatf("b2b_irq_%0d", k), {31'd0, irq}, 32'd0);
      tick();
    end
    check("after_stop_tx", {31'd0, tx}, 32'd1);
    check("after_stop_irq", {31'd0, irq}, 32'd0);
    tick();
    check("irq_rise", {31'd0, irq}, 32'd1);

    // Error responses have no side effects
    bus(1'b0, 32'h10, 32'h0, rd, rv, er);
    check("err_rd_resp", {30'd0, rv, er}, 32'h3);
    check("err_rd_rdata", rd, 32'h0);
    bus(1'b1, 32'h40, 32'hAB, rd, rv, er);
    check("err_wr_resp", {30'd0, rv, er}, 32'h3);
    check("err_wr_rdata", rd, 32'h0);
    bus(1'b1, 32'h48, 32'h7, rd, rv, er);
    check("err_div_resp", {30'd0, rv, er}, 32'h3);
    rdchk("err_status", 32'h4, 32'h2);
    rdchk("err_div_kept", 32'h8, 32'd1);
    rdchk("irq_en_rd", 32'hC, 32'd1);

    // DIV=0 behaves as 1
    wr("div0", 32'h8, 32'd0);
    rdchk("div0_rd", 32'h8, 32'd0);
    wr("push_01", 32'h0, 32'h01);
    tick();
    fr = {1'b1, 8'h01, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("div0_tx_%0d", k), {31'd0, tx}, {31'd0, fr[k]});
      tick();
    end
    check("div0_idle", {31'd0, tx}, 32'd1);

    // Reset during data bit 3
    wr("div4b", 32'h8, 32'd4);
    wr("push_f7", 32'h0, 32'hF7);
    wr("push_33", 32'h0, 32'h33);
    repeat (16) tick();
    check("bit3_low", {31'd0, tx}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_tx", {31'd0, tx}, 32'd1);
    rdchk("post_rst_status", 32'h4, 32'h2);
    rdchk("post_rst_div", 32'h8, 32'd16);
    rdchk("post_rst_irq_en", 32'hC, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
